pnu_mux_stream: RTL
===================

# pnu_mux_stream

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It generalises the team's fixed 8:1 combinational selector. It adds a one-entry output register, backpressure, and a selectable mode: manual (external select) or round-robin arbitration among valid channels. It sits between multiple producer streams and a single consumer.

## Interface
- W, 8, data width per channel (≥1)
- N, 8, channel count (2..16)
- SW, 3, select/channel-index width; ≥ clog2(N)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*W  channel c occupies bits [c*W+W-1 : c*W]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; combinational
- mode  in  1  0 = manual select, 1 = round-robin
- sel  in  SW  manual-mode channel index
- out_data  out  W  registered output data
- out_ch  out  SW  registered index of the channel that supplied out_data
- out_valid  out  1  registered output valid
- out_ready  in  1  consumer ready

## Operation
- Output stage: one register entry holding out_data, out_ch and out_valid.
- load_en = !out_valid || out_ready.
- Candidate channel `cand`:
  - Manual (mode=0): cand = sel when sel < N and in_valid[sel]=1. Otherwise there is no candidate.
  - Round-robin (mode=1): search starts at pointer ptr and proceeds ptr, ptr+1, … N-1, 0, … ptr-1. cand is the first channel with in_valid=1. If no channel is valid, there is no candidate.
- in_ready[c] = load_en && (c == cand); at most one bit set. All bits are 0 when there is no candidate.
- Accept: when in_valid[cand] && in_ready[cand]:
  - the next edge loads out_data ← channel cand data, out_ch ← cand, out_valid ← 1;
  - in round-robin mode, ptr ← cand+1, wrapping N-1 → 0.
- Drain without accept: out_valid=1, out_ready=1 and no candidate → out_valid ← 0 next edge; out_data and out_ch hold their values.
- Stall: out_valid=1 and out_ready=0 → out_data, out_ch and out_valid hold; all in_ready=0.
- ptr is unchanged in manual mode and unchanged on cycles with no accept.
- Mode or sel changes affect only the next selection. A held output entry is never altered by them.
- sel ≥ N in manual mode is legal: no transfer occurs and no error is raised.

## Timing
- Reset (async assert, synchronous-clean deassert assumed by the system): out_valid=0, out_data=0, out_ch=0, ptr=0.
- With rst high: in_ready=0 for all channels, because cand is suppressed during reset.
- Latency: input accepted at edge k → out_valid=1 with that data after edge k (visible in cycle k+1).
- Throughput: one transfer per cycle when out_ready is held 1 (accept and drain on the same edge).
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. It must not depend on in_data.
- Simultaneous drain and accept on one edge: the new entry replaces the old one, and out_valid stays 1.
- Reset mid-transfer: the entry is discarded and ptr returns to 0. The first post-reset round-robin grant goes to the lowest valid channel.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants are 0,1,…,N-1,0,… and every channel is served once per N accepts.

## Test plan
- Reset: assert rst with in_valid all 1 → out_valid=0, out_data=0, out_ch=0, in_ready=0. Deassert, mode=1 → first accept is channel 0.
- Manual select, N=8, W=8: channel c data = 8'h10+c, all valid, mode=0, sel=5, out_ready=1 → in_ready=8'b0010_0000. Next cycle out_data=8'h15, out_ch=5, out_valid=1.
- Out-of-range select, N=6, SW=3: sel=7, all valid → in_ready=0 and out_valid falls to 0 after the drain.
- Round-robin wrap: N=8, only channels 6, 7 and 1 valid, ptr=0, out_ready=1 → grant order is 1, 6, 7, 1, 6, … Confirm ptr wraps 7→0.
- Backpressure: accept data 8'hA5, then hold out_ready=0 for 3 cycles while changing inputs → out_data stays 8'hA5, in_ready=0. Release → next grant follows ptr.
- Throughput/fairness: all 8 valid, out_ready=1 for 16 cycles → 16 transfers, out_ch sequence 0..7,0..7, no bubbles.

Source files
------------

// File: rtl/pnu_mux_stream.sv
// pnu_mux_stream: N-channel, W-bit registered stream multiplexer.
//
// Each input channel has a valid/ready handshake. Channels compete for a
// single one-entry output register. mode selects the arbitration:
// manual (channel given by sel) or round-robin among valid channels.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    N*W packed channel data; channel c at [c*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   mode       0 = manual select, 1 = round-robin
//   sel        channel index used in manual mode
//   out_data   registered output data
//   out_ch     registered index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
module pnu_mux_stream #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_ch;
  logic          r_valid;

  logic          w_load_en;
  logic          w_cand_vld;
  logic [SW-1:0] w_cand;
  logic          w_accept;
  logic [W-1:0]  w_cand_data;

  // The output entry can take new data when it is empty or being drained.
  assign w_load_en = !r_valid || out_ready;
  assign w_accept  = w_cand_vld && w_load_en;

  // Candidate selection. Suppressed while in reset so no channel sees ready.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = '0;
    if (!rst) begin
      if (!mode) begin
        // Out-of-range sel matches no channel, so it simply yields no candidate.
        for (int unsigned c = 0; c < N; c++) begin
          if (sel == SW'(c) && in_valid[c]) begin
            w_cand_vld = 1'b1;
            w_cand     = SW'(c);
          end
        end
      end else begin
        // Round-robin: first valid channel at or above ptr, else the lowest
        // valid channel below ptr (the wrapped part of the search).
        for (int unsigned c = 0; c < N; c++) begin
          if (!w_cand_vld && in_valid[c] && SW'(c) >= r_ptr) begin
            w_cand_vld = 1'b1;
            w_cand     = SW'(c);
          end
        end
        for (int unsigned c = 0; c < N; c++) begin
          if (!w_cand_vld && in_valid[c] && SW'(c) < r_ptr) begin
            w_cand_vld = 1'b1;
            w_cand     = SW'(c);
          end
        end
      end
    end
  end

  // Data of the candidate channel.
  always_comb begin
    w_cand_data = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (w_cand == SW'(c)) begin
        w_cand_data = in_data[c*W +: W];
      end
    end
  end

  // Ready goes only to the candidate, and only when the entry can load.
  always_comb begin
    in_ready = '0;
    for (int unsigned c = 0; c < N; c++) begin
      in_ready[c] = w_accept && (w_cand == SW'(c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      // Covers simultaneous drain and accept: the new entry replaces the old.
      r_data  <= w_cand_data;
      r_ch    <= w_cand;
      r_valid <= 1'b1;
      if (mode) begin
        r_ptr <= (w_cand == SW'(N - 1)) ? '0 : w_cand + SW'(1);
      end
    end else if (out_ready) begin
      // Drain without replacement; data and channel hold their last values.
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule
